// File: rtl/polar_synth.sv
// polar_synth: four magnitude/phase setpoints are turned into I/Q by one shared iterative
// CORDIC, then every channel is continuously mixed against the shared LO into a 14-bit DAC sample.
module polar_synth #(
    parameter int W_CORDIC = 31,
    parameter int N_ITER   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [W_CORDIC-1:0] mag_ref,
    input  logic [W_CORDIC-1:0] mag_a,
    input  logic [W_CORDIC-1:0] mag_b,
    input  logic [W_CORDIC-1:0] mag_c,
    input  logic [W_CORDIC:0]   phase_ref,
    input  logic [W_CORDIC:0]   phase_a,
    input  logic [W_CORDIC:0]   phase_b,
    input  logic [W_CORDIC:0]   phase_c,
    input  logic                in_strobe,
    input  logic [17:0]         lo_cos,
    input  logic [17:0]         lo_sin,
    output logic [13:0]         dac_ref,
    output logic [13:0]         dac_a,
    output logic [13:0]         dac_b,
    output logic [13:0]         dac_c,
    output logic                busy,
    output logic                out_strobe,
    output logic                dropped
);

    typedef enum logic [2:0] {IDLE, LOAD, ROTATE, STORE, COMMIT} state_t;

    state_t state, state_next;

    logic [1:0]         ch;
    logic [4:0]         iter;
    logic signed [18:0] x, y;
    logic [17:0]        z;

    logic [17:0] ph_sh    [4];
    logic [16:0] mag_sh   [4];
    logic [17:0] shadow_i [4];
    logic [17:0] shadow_q [4];
    logic [17:0] active_i [4];
    logic [17:0] active_q [4];

    logic [W_CORDIC:0] sum_a, sum_b, sum_c;
    logic [33:0]       scaled;
    logic [18:0]       x_mag, x_load;
    logic [17:0]       z_raw, z_load;
    logic              fold;
    logic signed [18:0] x_sh, y_sh;

    logic [35:0] prod_c [4];
    logic [35:0] prod_s [4];
    logic [36:0] diff   [4];
    logic [13:0] dac    [4];

    function automatic logic [17:0] atan_lut(input logic [4:0] i);
        case (i)
            5'd0:    atan_lut = 18'd32768;
            5'd1:    atan_lut = 18'd19344;
            5'd2:    atan_lut = 18'd10221;
            5'd3:    atan_lut = 18'd5188;
            5'd4:    atan_lut = 18'd2604;
            5'd5:    atan_lut = 18'd1303;
            5'd6:    atan_lut = 18'd652;
            5'd7:    atan_lut = 18'd326;
            5'd8:    atan_lut = 18'd163;
            5'd9:    atan_lut = 18'd81;
            5'd10:   atan_lut = 18'd41;
            5'd11:   atan_lut = 18'd20;
            5'd12:   atan_lut = 18'd10;
            5'd13:   atan_lut = 18'd5;
            5'd14:   atan_lut = 18'd3;
            5'd15:   atan_lut = 18'd1;
            5'd16:   atan_lut = 18'd1;
            default: atan_lut = 18'd0;
        endcase
    endfunction

    function automatic logic [17:0] sat18(input logic [18:0] v);
        if (v[18] != v[17])
            sat18 = v[18] ? 18'h20000 : 18'h1FFFF;
        else
            sat18 = v[17:0];
    endfunction

    function automatic logic [13:0] sat14(input logic [19:0] v);
        if (v[19:13] == {7{v[13]}})
            sat14 = v[13:0];
        else
            sat14 = v[19] ? 14'h2000 : 14'h1FFF;
    endfunction

    assign sum_a = phase_ref + phase_a;
    assign sum_b = phase_ref + phase_b;
    assign sum_c = phase_ref + phase_c;

    // Gain precompensation and quadrant fold keep the CORDIC inside its convergence range.
    assign scaled = {17'd0, mag_sh[ch]} * 34'd79590;
    assign x_mag  = {2'b00, scaled[33:17]};
    assign z_raw  = ph_sh[ch];
    assign fold   = z_raw[17] ^ z_raw[16];
    assign x_load = fold ? 19'd0 - x_mag : x_mag;
    assign z_load = fold ? z_raw + 18'h20000 : z_raw;

    assign x_sh = x >>> iter;
    assign y_sh = y >>> iter;

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        out_strobe = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (in_strobe)
                    state_next = LOAD;
            end
            LOAD:    state_next = ROTATE;
            ROTATE:  if (iter == 5'(N_ITER - 1)) state_next = STORE;
            STORE:   state_next = (ch == 2'd3) ? COMMIT : LOAD;
            COMMIT: begin
                out_strobe = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ch      <= 2'd0;
            iter    <= 5'd0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            dropped <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                ph_sh[k]    <= '0;
                mag_sh[k]   <= '0;
                shadow_i[k] <= '0;
                shadow_q[k] <= '0;
                active_i[k] <= '0;
                active_q[k] <= '0;
            end
        end else begin
            dropped <= in_strobe && busy;
            if (in_strobe && !busy) begin
                ph_sh[0]  <= phase_ref[W_CORDIC -: 18];
                ph_sh[1]  <= sum_a[W_CORDIC -: 18];
                ph_sh[2]  <= sum_b[W_CORDIC -: 18];
                ph_sh[3]  <= sum_c[W_CORDIC -: 18];
                mag_sh[0] <= mag_ref[W_CORDIC-1 -: 17];
                mag_sh[1] <= mag_a[W_CORDIC-1 -: 17];
                mag_sh[2] <= mag_b[W_CORDIC-1 -: 17];
                mag_sh[3] <= mag_c[W_CORDIC-1 -: 17];
            end
            case (state)
                IDLE: ch <= 2'd0;
                LOAD: begin
                    x    <= x_load;
                    y    <= '0;
                    z    <= z_load;
                    iter <= 5'd0;
                end
                ROTATE: begin
                    x    <= z[17] ? x + y_sh : x - y_sh;
                    y    <= z[17] ? y - x_sh : y + x_sh;
                    z    <= z[17] ? z + atan_lut(iter) : z - atan_lut(iter);
                    iter <= iter + 5'd1;
                end
                STORE: begin
                    shadow_i[ch] <= sat18(x);
                    shadow_q[ch] <= sat18(y);
                    ch           <= ch + 2'd1;
                end
                COMMIT: begin
                    for (int k = 0; k < 4; k++) begin
                        active_i[k] <= shadow_i[k];
                        active_q[k] <= shadow_q[k];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < 4; k++)
            diff[k] = {prod_c[k][35], prod_c[k]} - {prod_s[k][35], prod_s[k]};
    end

    // Upconverter runs every cycle: product register, then difference/floor/saturate register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 4; k++) begin
                prod_c[k] <= '0;
                prod_s[k] <= '0;
                dac[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                prod_c[k] <= {{18{active_i[k][17]}}, active_i[k]} * {{18{lo_cos[17]}}, lo_cos};
                prod_s[k] <= {{18{active_q[k][17]}}, active_q[k]} * {{18{lo_sin[17]}}, lo_sin};
                dac[k]    <= sat14(diff[k][36:17]);
            end
        end
    end

    assign dac_ref = dac[0];
    assign dac_a   = dac[1];
    assign dac_b   = dac[2];
    assign dac_c   = dac[3];

    // Bits below the CORDIC resolution are intentionally discarded.
    logic unused_bits;
    assign unused_bits = ^{mag_ref[W_CORDIC-18:0], mag_a[W_CORDIC-18:0],
                           mag_b[W_CORDIC-18:0], mag_c[W_CORDIC-18:0],
                           sum_a[W_CORDIC-18:0], sum_b[W_CORDIC-18:0],
                           sum_c[W_CORDIC-18:0], scaled[16:0],
                           diff[0][16:0], diff[1][16:0], diff[2][16:0], diff[3][16:0]};

endmodule

// File: tb/tb_polar_synth.sv
`timescale 1ns/1ps
// Directed bench for polar_synth: reset state, zero/relative/wrapped phases, quadrant fold,
// collision drop, DAC saturation, upconverter latency and mid-conversion reset.
module tb_polar_synth;

    localparam int N_ITER       = 16;
    localparam int COMMIT_CYCLE = 4 * (N_ITER + 2) + 1;

    localparam logic [30:0] MAG_UNIT = 31'h0400_0000;
    localparam logic [30:0] MAG_HALF = 31'h0200_0000;
    localparam logic [30:0] MAG_MAX  = 31'h7FFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [30:0] mag_ref, mag_a, mag_b, mag_c;
    logic [31:0] phase_ref, phase_a, phase_b, phase_c;
    logic        in_strobe;
    logic [17:0] lo_cos, lo_sin;
    logic [13:0] dac_ref, dac_a, dac_b, dac_c;
    logic        busy, out_strobe, dropped;

    int n_checks = 0;
    int n_fail   = 0;

    polar_synth #(.W_CORDIC(31), .N_ITER(N_ITER)) dut (
        .clk(clk), .reset(reset),
        .mag_ref(mag_ref), .mag_a(mag_a), .mag_b(mag_b), .mag_c(mag_c),
        .phase_ref(phase_ref), .phase_a(phase_a), .phase_b(phase_b), .phase_c(phase_c),
        .in_strobe(in_strobe), .lo_cos(lo_cos), .lo_sin(lo_sin),
        .dac_ref(dac_ref), .dac_a(dac_a), .dac_b(dac_b), .dac_c(dac_c),
        .busy(busy), .out_strobe(out_strobe), .dropped(dropped)
    );

    always #5 clk = ~clk;

    function automatic int sdac(input logic [13:0] v);
        return int'($signed(v));
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected,
                               input int tol = 0);
        int delta;
        n_checks++;
        delta = observed - expected;
        if (delta < 0) delta = -delta;
        if (delta > tol) begin
            n_fail++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (tolerance %0d)",
                     tag, observed, expected, tol);
        end
    endtask

    task automatic applyStimulus(input logic [30:0] m_ref, input logic [31:0] p_ref,
                                 input logic [30:0] m_a,   input logic [31:0] p_a,
                                 input logic [30:0] m_b,   input logic [31:0] p_b,
                                 input logic [30:0] m_c,   input logic [31:0] p_c);
        mag_ref = m_ref; phase_ref = p_ref;
        mag_a   = m_a;   phase_a   = p_a;
        mag_b   = m_b;   phase_b   = p_b;
        mag_c   = m_c;   phase_c   = p_c;
    endtask

    // Called just after a falling edge; that cycle is T=0 and carries the strobe.
    task automatic runConversion(input string tag, input int collide_at, output int ref_pre);
        int busy_cycles, strobes, drops;
        busy_cycles = 0;
        strobes     = 0;
        drops       = 0;
        ref_pre     = 0;
        in_strobe   = 1'b1;
        for (int t = 1; t <= COMMIT_CYCLE + 7; t++) begin
            @(negedge clk);
            in_strobe = (t == collide_at);
            if (t == collide_at)
                applyStimulus(31'd0, 32'h4000_0000, MAG_MAX, 32'h1234_5678,
                              31'd0, 32'h8000_0000, 31'd0, 32'h4000_0000);
            busy_cycles += int'(busy);
            strobes     += int'(out_strobe);
            drops       += int'(dropped);
            if (t == 1)
                checkOutput({tag, "_busy_start"}, int'(busy), 1);
            if (t == COMMIT_CYCLE - 1)
                checkOutput({tag, "_no_early_strobe"}, int'(out_strobe), 0);
            if (t == COMMIT_CYCLE)
                checkOutput({tag, "_out_strobe"}, int'(out_strobe), 1);
            if (t == COMMIT_CYCLE + 1)
                checkOutput({tag, "_busy_end"}, int'(busy), 0);
            if (collide_at != 0 && t == collide_at + 1)
                checkOutput({tag, "_dropped"}, int'(dropped), 1);
            if (t == COMMIT_CYCLE + 2)
                ref_pre = sdac(dac_ref);
        end
        checkOutput({tag, "_busy_cycles"}, busy_cycles, COMMIT_CYCLE);
        checkOutput({tag, "_strobe_count"}, strobes, 1);
        checkOutput({tag, "_drop_count"}, drops, (collide_at != 0) ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pre, idle_strobes, idle_nonzero;
        reset     = 1'b0;
        in_strobe = 1'b0;
        lo_cos    = 18'd0;
        lo_sin    = 18'd0;
        applyStimulus(31'd0, 32'd0, 31'd0, 32'd0, 31'd0, 32'd0, 31'd0, 32'd0);

        // Reset held with random activity on every input.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            applyStimulus(31'($urandom), $urandom, 31'($urandom), $urandom,
                          31'($urandom), $urandom, 31'($urandom), $urandom);
            lo_cos    = 18'($urandom);
            lo_sin    = 18'($urandom);
            in_strobe = 1'($urandom);
        end
        @(negedge clk);
        reset     = 1'b1;
        in_strobe = 1'b0;
        checkOutput("rst_dac_ref", sdac(dac_ref), 0);
        checkOutput("rst_dac_a", sdac(dac_a), 0);
        checkOutput("rst_dac_b", sdac(dac_b), 0);
        checkOutput("rst_dac_c", sdac(dac_c), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_out_strobe", int'(out_strobe), 0);
        checkOutput("rst_dropped", int'(dropped), 0);

        idle_strobes = 0;
        idle_nonzero = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lo_cos = 18'($urandom);
            lo_sin = 18'($urandom);
            idle_strobes += int'(out_strobe) + int'(busy);
            if (dac_ref != 0 || dac_a != 0 || dac_b != 0 || dac_c != 0) idle_nonzero++;
        end
        checkOutput("idle_strobe_or_busy", idle_strobes, 0);
        checkOutput("idle_dac_nonzero", idle_nonzero, 0);

        // Zero phase, zero magnitude, half magnitude, full-scale saturation; collision at T=40.
        applyStimulus(MAG_UNIT, 32'd0, 31'd0, 32'd0, MAG_HALF, 32'd0, MAG_MAX, 32'd0);
        lo_cos = 18'd79590;
        lo_sin = 18'd0;
        runConversion("zero", 40, pre);
        checkOutput("zero_ref_before_latency", pre, 0);
        checkOutput("zero_dac_ref", sdac(dac_ref), 2487, 3);
        checkOutput("zero_dac_a", sdac(dac_a), 0);
        checkOutput("zero_dac_b", sdac(dac_b), 1243, 3);
        checkOutput("sat_dac_c", sdac(dac_c), 8191);
        lo_cos = 18'd0;
        lo_sin = -18'sd79590;
        @(negedge clk);
        checkOutput("lo_latency_old_c", sdac(dac_c), 8191);
        @(negedge clk);
        checkOutput("zero_q_ref", sdac(dac_ref), 0, 3);
        checkOutput("zero_q_a", sdac(dac_a), 0);

        // Relative phases of +pi/2 and -pi/2 viewed through the sine LO.
        applyStimulus(31'd0, 32'd0, MAG_UNIT, 32'h4000_0000, MAG_UNIT, 32'hC000_0000, 31'd0, 32'd0);
        runConversion("rel", 0, pre);
        checkOutput("rel_dac_a_plus", sdac(dac_a), 2487, 3);
        checkOutput("rel_dac_b_minus", sdac(dac_b), -2487, 3);
        checkOutput("rel_dac_ref_zero", sdac(dac_ref), 0);
        checkOutput("rel_dac_c_zero", sdac(dac_c), 0);

        // Phase sum wraps to -7pi/8 on b; reference at +7pi/8 exercises the other fold.
        applyStimulus(MAG_UNIT, 32'h7000_0000, 31'd0, 32'd0, MAG_UNIT, 32'h2000_0000, 31'd0, 32'd0);
        runConversion("wrap", 0, pre);
        checkOutput("wrap_q_ref", sdac(dac_ref), 951, 4);
        checkOutput("wrap_q_b", sdac(dac_b), -952, 4);
        lo_cos = 18'd79590;
        lo_sin = 18'd0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("wrap_i_ref", sdac(dac_ref), -2298, 4);
        checkOutput("wrap_i_b", sdac(dac_b), -2298, 4);

        // Reset during conversion at T=30, released at T=31.
        applyStimulus(MAG_UNIT, 32'd0, MAG_UNIT, 32'd0, MAG_UNIT, 32'd0, MAG_UNIT, 32'd0);
        in_strobe    = 1'b1;
        idle_strobes = 0;
        idle_nonzero = 0;
        for (int t = 1; t <= 120; t++) begin
            @(negedge clk);
            in_strobe = 1'b0;
            idle_strobes += int'(out_strobe);
            if (t == 30) begin
                checkOutput("mid_busy_before", int'(busy), 1);
                reset = 1'b0;
            end
            if (t == 31) begin
                reset = 1'b1;
                checkOutput("mid_busy_after", int'(busy), 0);
                checkOutput("mid_dac_ref", sdac(dac_ref), 0);
                checkOutput("mid_dac_a", sdac(dac_a), 0);
                checkOutput("mid_dac_b", sdac(dac_b), 0);
                checkOutput("mid_dac_c", sdac(dac_c), 0);
            end
            if (t >= 31 && (dac_ref != 0 || dac_a != 0 || dac_b != 0 || dac_c != 0))
                idle_nonzero++;
        end
        checkOutput("mid_no_strobe", idle_strobes, 0);
        checkOutput("mid_dac_stay_zero", idle_nonzero, 0);

        runConversion("fresh", 0, pre);
        checkOutput("fresh_ref_before_latency", pre, 0);
        checkOutput("fresh_dac_ref", sdac(dac_ref), 2487, 3);
        checkOutput("fresh_dac_c", sdac(dac_c), 2487, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
